// File: rtl/status_stack_reg.sv
// CPU status register {mode, imask, alu_status} with a hardware save stack for nested interrupts.
// Optional STATUS_STACK_ERR_EN: refuse stack overflow/underflow and raise a sticky err flag.
module status_stack_reg #(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned MODE_W = 1,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned STATUS_W = MODE_W + 1 + FLAG_W,
  localparam int unsigned PTR_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output wire  [STATUS_W-1:0] a,
  output wire  [STATUS_W-1:0] b,
  input  logic                oe_a,
  input  logic                oe_b,
  input  logic [STATUS_W-1:0] in,
  input  logic                ld,
  input  logic [FLAG_W-1:0]   alu_status_in,
  input  logic                ld_alu_status,
  input  logic                imask_in,
  input  logic                ld_imask,
  input  logic [MODE_W-1:0]   mode_in,
  input  logic                ld_mode,
  input  logic                push,
  input  logic                pop,
  output logic [STATUS_W-1:0] value,
  output logic [PTR_W-1:0]    depth,
  output logic                full,
  output logic                empty,
  output logic                err
);

  localparam int unsigned     IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MODE_W-1:0] SUPERVISOR = MODE_W'(1);
  localparam logic [PTR_W-1:0]  DEPTH_P    = PTR_W'(DEPTH);

  logic [FLAG_W-1:0]   alu_q,   alu_d;
  logic                imask_q, imask_d;
  logic [MODE_W-1:0]   mode_q,  mode_d;
  logic [PTR_W-1:0]    depth_q, depth_d;
  logic                full_q,  full_d;
  logic                empty_q, empty_d;
  logic                err_q,   err_d;

  logic [STATUS_W-1:0] stack_q [DEPTH];
  logic                stack_we;
  logic [IDX_W-1:0]    stack_widx;
  logic [STATUS_W-1:0] pop_data;

  assign value = {mode_q, imask_q, alu_q};
  assign depth = depth_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign err   = err_q;

  assign a = oe_a ? value : {STATUS_W{1'bz}};
  assign b = oe_b ? value : {STATUS_W{1'bz}};

  assign pop_data = stack_q[IDX_W'(depth_q - PTR_W'(1))];

  // Next-state: push > pop > ld > field loads
  always_comb begin
    alu_d      = alu_q;
    imask_d    = imask_q;
    mode_d     = mode_q;
    depth_d    = depth_q;
    err_d      = err_q;
    stack_we   = 1'b0;
    stack_widx = IDX_W'(depth_q);

    if (push) begin
      mode_d  = SUPERVISOR;
      imask_d = 1'b1;
      if (depth_q == DEPTH_P) begin
`ifdef STATUS_STACK_ERR_EN
        err_d      = 1'b1;
`else
        stack_we   = 1'b1;
        stack_widx = IDX_W'(DEPTH - 1);
`endif
      end else begin
        stack_we = 1'b1;
        depth_d  = depth_q + PTR_W'(1);
      end
    end else if (pop) begin
      if (depth_q == '0) begin
`ifdef STATUS_STACK_ERR_EN
        err_d = 1'b1;
`endif
      end else begin
        {mode_d, imask_d, alu_d} = pop_data;
        depth_d                  = depth_q - PTR_W'(1);
      end
    end else if (ld) begin
      // USER mode may only touch the ALU flags
      if (mode_q != '0) begin
        {mode_d, imask_d, alu_d} = in;
      end else begin
        alu_d = in[FLAG_W-1:0];
      end
    end else begin
      if (ld_alu_status) alu_d   = alu_status_in;
      if (ld_imask)      imask_d = imask_in;
      if (ld_mode)       mode_d  = mode_in;
    end

    full_d  = (depth_d == DEPTH_P);
    empty_d = (depth_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      imask_q <= 1'b1;
      mode_q  <= SUPERVISOR;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      imask_q <= imask_d;
      mode_q  <= mode_d;
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset; depth alone marks validity
  always_ff @(posedge clk) begin
    if (stack_we) stack_q[stack_widx] <= value;
  end

endmodule

// File: tb/tb_status_stack_reg.sv
// Self-checking bench for status_stack_reg (DEPTH=4, FLAG_W=4, MODE_W=1): vector table plus corner sequences.
module tb_status_stack_reg;

`ifdef STATUS_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  wire  [5:0] a, b;
  logic       oe_a, oe_b;
  logic [5:0] in;
  logic       ld;
  logic [3:0] alu_status_in;
  logic       ld_alu_status;
  logic       imask_in, ld_imask;
  logic       mode_in, ld_mode;
  logic       push, pop;
  logic [5:0] value;
  logic [2:0] depth;
  logic       full, empty, err;

  status_stack_reg dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .oe_a(oe_a), .oe_b(oe_b),
    .in(in), .ld(ld), .alu_status_in(alu_status_in), .ld_alu_status(ld_alu_status),
    .imask_in(imask_in), .ld_imask(ld_imask), .mode_in(mode_in), .ld_mode(ld_mode),
    .push(push), .pop(pop), .value(value), .depth(depth),
    .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;     logic [5:0] in;
    logic       ld_alu; logic [3:0] alu;
    logic       ld_im;  logic       im;
    logic       ld_md;  logic       md;
    logic       push;   logic       pop;
    logic [5:0] exp_v;  logic [2:0] exp_d; logic exp_e;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] v;
    logic [2:0] d;
    logic       e;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic l, logic [5:0] i, logic la, logic [3:0] al,
                              logic li, logic im, logic lm, logic md, logic pu, logic po,
                              logic [5:0] ev, logic [2:0] ed, logic ee);
    vec_t v;
    v.ld = l; v.in = i; v.ld_alu = la; v.alu = al; v.ld_im = li; v.im = im;
    v.ld_md = lm; v.md = md; v.push = pu; v.pop = po;
    v.exp_v = ev; v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    oe_a = 0; oe_b = 0; in = '0; ld = 0; alu_status_in = '0; ld_alu_status = 0;
    imask_in = 0; ld_imask = 0; mode_in = 0; ld_mode = 0; push = 0; pop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [5:0] ev, input logic [2:0] ed, input logic ee);
    check({tag, ".value"}, 32'(value), 32'(ev));
    check({tag, ".depth"}, 32'(depth), 32'(ed));
    check({tag, ".full"},  32'(full),  32'(ed == 3'd4));
    check({tag, ".empty"}, 32'(empty), 32'(ed == 3'd0));
    check({tag, ".err"},   32'(err),   32'(ee));
  endtask

  // Drive one vector on the falling edge, score it just after the next rising edge
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    ld = v.ld; in = v.in; ld_alu_status = v.ld_alu; alu_status_in = v.alu;
    ld_imask = v.ld_im; imask_in = v.im; ld_mode = v.ld_md; mode_in = v.md;
    push = v.push; pop = v.pop;
    sb.push_back('{idx, v.exp_v, v.exp_d, ERR_EN & v.exp_e});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_state($sformatf("vec%0d", e.idx), e.v, e.d, e.e);
    clear_inputs();
  endtask

  initial begin
    logic [5:0] zv;
    zv = 6'bzzzzzz;
    clear_inputs();
    rst = 1'b0;

    //          ld in        la alu     li im lm md pu po  exp_v      d     e
    vecs[0]  = mk(1, 6'b011010, 0, 4'h0,  0, 0, 0, 0, 0, 0, 6'b011010, 3'd0, 0);
    vecs[1]  = mk(1, 6'b100101, 0, 4'h0,  0, 0, 0, 0, 0, 0, 6'b010101, 3'd0, 0);
    vecs[2]  = mk(0, 6'b000000, 1, 4'h3,  1, 0, 0, 0, 0, 0, 6'b000011, 3'd0, 0);
    vecs[3]  = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110011, 3'd1, 0);
    vecs[4]  = mk(0, 6'b000000, 1, 4'hC,  0, 0, 0, 0, 0, 0, 6'b111100, 3'd1, 0);
    vecs[5]  = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b000011, 3'd0, 0);
    vecs[6]  = mk(0, 6'b000000, 0, 4'h0,  0, 0, 1, 1, 0, 0, 6'b100011, 3'd0, 0);
    vecs[7]  = mk(0, 6'b000000, 1, 4'h1,  0, 0, 0, 0, 0, 0, 6'b100001, 3'd0, 0);
    vecs[8]  = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110001, 3'd1, 0);
    vecs[9]  = mk(0, 6'b000000, 1, 4'h2,  0, 0, 0, 0, 0, 0, 6'b110010, 3'd1, 0);
    vecs[10] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110010, 3'd2, 0);
    vecs[11] = mk(0, 6'b000000, 1, 4'h3,  0, 0, 0, 0, 0, 0, 6'b110011, 3'd2, 0);
    vecs[12] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110011, 3'd3, 0);
    vecs[13] = mk(0, 6'b000000, 1, 4'h4,  0, 0, 0, 0, 0, 0, 6'b110100, 3'd3, 0);
    vecs[14] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110100, 3'd4, 0);
    vecs[15] = mk(0, 6'b000000, 1, 4'h7,  0, 0, 0, 0, 0, 0, 6'b110111, 3'd4, 0);
    vecs[16] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 1, 0, 6'b110111, 3'd4, 1);
    vecs[17] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b110100, 3'd3, 1);
    vecs[18] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b110011, 3'd2, 1);
    vecs[19] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b110010, 3'd1, 1);
    vecs[20] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b100001, 3'd0, 1);
    vecs[21] = mk(0, 6'b000000, 0, 4'h0,  0, 0, 0, 0, 0, 1, 6'b100001, 3'd0, 1);
    // Without overflow protection the 5th push replaced entry 3 with the current status
    if (!ERR_EN) vecs[17].exp_v = 6'b110111;

    do_reset();
    #1;
    check_state("reset", 6'b110000, 3'd0, 1'b0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Tri-state buses follow the enables; value is 100001 here
    @(negedge clk);
    oe_a = 1;
    #1;
    check("bus_a_on", 32'(a), 32'(6'b100001));
    check("bus_b_off", 32'(b), 32'(zv));
    oe_a = 0; oe_b = 1;
    #1;
    check("bus_b_on", 32'(b), 32'(6'b100001));
    check("bus_a_off", 32'(a), 32'(zv));
    oe_b = 0;

    // Pop on empty straight after reset
    do_reset();
    apply(mk(0, 6'b0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 6'b110000, 3'd0, 1), 100);

    // Simultaneous push and pop: push wins
    do_reset();
    apply(mk(0, 6'b0, 1, 4'h9, 0, 0, 0, 0, 0, 0, 6'b111001, 3'd0, 0), 101);
    apply(mk(0, 6'b0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 6'b111001, 3'd1, 0), 102);
    apply(mk(1, 6'b000101, 0, 4'h0, 0, 0, 0, 0, 1, 1, 6'b111001, 3'd2, 0), 103);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_state("async_rst", 6'b110000, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
